// File: rtl/atm_timer_pkg.sv
// Shared types for the ATM timeout channels: per-channel FSM states and
// the encoding of the one-shot/periodic mode bit.
package atm_timer_pkg;

  typedef enum logic [1:0] {
    TMR_IDLE   = 2'd0,
    TMR_RUN    = 2'd1,
    TMR_PAUSED = 2'd2,
    TMR_DONE   = 2'd3
  } timer_state_e;

  localparam logic TMR_MODE_ONESHOT  = 1'b0;
  localparam logic TMR_MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/atm_timer_channel.sv
// One timeout channel: control FSM, up-counter with latched threshold/mode,
// registered one-cycle time_out pulse and sticky expired flag.
module atm_timer_channel
  import atm_timer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             restart,
  input  logic             stop,
  input  logic             pause,
  input  logic             periodic,
  input  logic [WIDTH-1:0] threshold,
  input  logic             expired_clr,
  output logic             running,
  output logic             time_out,
  output logic             expired,
  output logic [WIDTH-1:0] count
);

  timer_state_e     state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] thr_q, thr_d;
  logic             mode_q, mode_d;
  logic             time_out_q, time_out_d;
  logic             expired_q, expired_d;
  logic             load;
  logic             terminal;

  // start only acts from IDLE/DONE; restart acts everywhere; stop overrides both
  assign load     = !stop && (restart || (start && (state_q == TMR_IDLE || state_q == TMR_DONE)));
  assign terminal = !stop && !load && (state_q == TMR_RUN) && !pause && (count_q == thr_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= TMR_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = TMR_IDLE;
    end else if (load) begin
      state_d = TMR_RUN;
    end else begin
      case (state_q)
        TMR_RUN: begin
          if (pause)                                      state_d = TMR_PAUSED;
          else if (terminal && mode_q != TMR_MODE_PERIODIC) state_d = TMR_DONE;
        end
        TMR_PAUSED: if (!pause) state_d = TMR_RUN;
        default: ;
      endcase
    end
  end

  always_comb begin
    running = (state_q == TMR_RUN) || (state_q == TMR_PAUSED);
  end

  // The resume edge out of PAUSED holds the count as well
  always_comb begin
    count_d    = count_q;
    thr_d      = thr_q;
    mode_d     = mode_q;
    time_out_d = terminal;
    expired_d  = expired_clr ? 1'b0 : expired_q;
    if (terminal) expired_d = 1'b1;
    if (stop) begin
      count_d = '0;
    end else if (load) begin
      count_d = '0;
      thr_d   = threshold;
      mode_d  = periodic;
    end else if (state_q == TMR_RUN && !pause) begin
      count_d = terminal ? '0 : count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q    <= '0;
      thr_q      <= '0;
      mode_q     <= TMR_MODE_ONESHOT;
      time_out_q <= 1'b0;
      expired_q  <= 1'b0;
    end else begin
      count_q    <= count_d;
      thr_q      <= thr_d;
      mode_q     <= mode_d;
      time_out_q <= time_out_d;
      expired_q  <= expired_d;
    end
  end

  assign time_out = time_out_q;
  assign expired  = expired_q;
  assign count    = count_q;

endmodule

// File: rtl/atm_multi_timer.sv
// Bank of independent timeout channels for the ATM controller FSM; the only
// shared logic is the OR of the sticky expired flags.
module atm_multi_timer
  import atm_timer_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       restart,
  input  logic [NUM_CH-1:0]       stop,
  input  logic [NUM_CH-1:0]       pause,
  input  logic [NUM_CH-1:0]       periodic,
  input  logic [NUM_CH*WIDTH-1:0] threshold,
  input  logic [NUM_CH-1:0]       expired_clr,
  output logic [NUM_CH-1:0]       running,
  output logic [NUM_CH-1:0]       time_out,
  output logic [NUM_CH-1:0]       expired,
  output logic [NUM_CH*WIDTH-1:0] count,
  output logic                    any_expired
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    atm_timer_channel #(.WIDTH(WIDTH)) u_ch (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start[i]),
      .restart     (restart[i]),
      .stop        (stop[i]),
      .pause       (pause[i]),
      .periodic    (periodic[i]),
      .threshold   (threshold[i*WIDTH +: WIDTH]),
      .expired_clr (expired_clr[i]),
      .running     (running[i]),
      .time_out    (time_out[i]),
      .expired     (expired[i]),
      .count       (count[i*WIDTH +: WIDTH])
    );
  end

  assign any_expired = |expired;

endmodule

// File: tb/tb_atm_multi_timer.sv
// Directed bench for atm_multi_timer: hand-computed expectations per cycle,
// checked with immediate assertions after each rising edge.
module tb_atm_multi_timer;

  localparam int NUM_CH = 4;
  localparam int W      = 32;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [NUM_CH-1:0]   start, restart, stop, pause, periodic, expired_clr;
  logic [NUM_CH*W-1:0] threshold;
  logic [NUM_CH-1:0]   running, time_out, expired;
  logic [NUM_CH*W-1:0] count;
  logic                any_expired;

  int checks   = 0;
  int failures = 0;

  logic [3:0]   exp_to, exp_ex, exp_run;
  logic [127:0] exp_cnt;
  int           exp_c;

  always #5 clk = ~clk;

  atm_multi_timer #(.NUM_CH(NUM_CH), .WIDTH(W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .restart     (restart),
    .stop        (stop),
    .pause       (pause),
    .periodic    (periodic),
    .threshold   (threshold),
    .expired_clr (expired_clr),
    .running     (running),
    .time_out    (time_out),
    .expired     (expired),
    .count       (count),
    .any_expired (any_expired)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start = '0; restart = '0; stop = '0; pause = '0; periodic = '0; expired_clr = '0;
    threshold = '0;
    tick();
    tick();
    check_output("rst_running", running, 0);
    check_output("rst_time_out", time_out, 0);
    check_output("rst_expired", expired, 0);
    check_output("rst_count", count, 0);
    check_output("rst_any", any_expired, 0);
    reset_n = 1'b1;
    tick();

    // one-shot, thr=5; the later threshold change must be ignored
    threshold[0 +: W] = 5; periodic[0] = 1'b0; start[0] = 1'b1;
    tick();
    start[0] = 1'b0; threshold[0 +: W] = 2;
    check_output("t1_c0_count", count[0 +: W], 0);
    check_output("t1_c0_running", running[0], 1);
    for (int c = 1; c <= 5; c++) begin
      tick();
      check_output($sformatf("t1_c%0d_count", c), count[0 +: W], 32'(c));
      check_output($sformatf("t1_c%0d_to", c), time_out[0], 0);
    end
    tick();
    check_output("t1_c6_to", time_out[0], 1);
    check_output("t1_c6_expired", expired[0], 1);
    check_output("t1_c6_running", running[0], 0);
    check_output("t1_c6_count", count[0 +: W], 0);
    check_output("t1_c6_any", any_expired, 1);
    tick();
    check_output("t1_c7_to", time_out[0], 0);
    check_output("t1_c7_expired", expired[0], 1);
    check_output("t1_c7_count", count[0 +: W], 0);
    expired_clr[0] = 1'b1;
    tick();
    expired_clr[0] = 1'b0;
    check_output("t1_clr_expired", expired[0], 0);
    check_output("t1_clr_any", any_expired, 0);

    // periodic, thr=3, expired_clr at c5
    threshold[W +: W] = 3; periodic[1] = 1'b1; start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    check_output("t2_c0_count", count[W +: W], 0);
    for (int c = 1; c <= 12; c++) begin
      expired_clr[1] = (c == 5);
      tick();
      check_output($sformatf("t2_c%0d_count", c), count[W +: W], 32'(c % 4));
      check_output($sformatf("t2_c%0d_to", c), time_out[1], (c % 4) == 0);
      check_output($sformatf("t2_c%0d_expired", c), expired[1], (c >= 4) && !(c >= 5 && c < 8));
      check_output($sformatf("t2_c%0d_running", c), running[1], 1);
    end
    expired_clr[1] = 1'b0;
    stop[1] = 1'b1;
    tick();
    stop[1] = 1'b0;
    check_output("t2_stop_running", running[1], 0);
    check_output("t2_stop_count", count[W +: W], 0);
    check_output("t2_stop_expired", expired[1], 1);
    expired_clr[1] = 1'b1;
    tick();
    expired_clr[1] = 1'b0;

    // thr=10 with pause sampled on edges 4..7; resume edge also holds
    threshold[2*W +: W] = 10; periodic[2] = 1'b0; start[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      pause[2] = (c >= 4 && c <= 7);
      tick();
      exp_c = (c <= 3) ? c : (c <= 8) ? 3 : (c <= 15) ? c - 5 : 0;
      check_output($sformatf("t3_c%0d_count", c), count[2*W +: W], 32'(exp_c));
      check_output($sformatf("t3_c%0d_to", c), time_out[2], c == 16);
      check_output($sformatf("t3_c%0d_running", c), running[2], c < 16);
    end
    pause[2] = 1'b0;
    expired_clr = '1;
    tick();
    expired_clr = '0;

    // thr=4, restart on the terminal cycle, then stop on the terminal cycle
    threshold[0 +: W] = 4; periodic[0] = 1'b0; start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      restart[0] = (c == 5);
      tick();
      exp_c = (c <= 4) ? c : (c == 5) ? 0 : (c <= 9) ? c - 5 : 0;
      check_output($sformatf("t4a_c%0d_count", c), count[0 +: W], 32'(exp_c));
      check_output($sformatf("t4a_c%0d_to", c), time_out[0], c == 10);
      check_output($sformatf("t4a_c%0d_expired", c), expired[0], c == 10);
      check_output($sformatf("t4a_c%0d_running", c), running[0], c < 10);
    end
    restart[0] = 1'b0;
    expired_clr[0] = 1'b1; start[0] = 1'b1;
    tick();
    expired_clr[0] = 1'b0; start[0] = 1'b0;
    check_output("t4b_c0_running", running[0], 1);
    check_output("t4b_c0_count", count[0 +: W], 0);
    check_output("t4b_c0_expired", expired[0], 0);
    for (int c = 1; c <= 6; c++) begin
      stop[0] = (c == 5);
      tick();
      check_output($sformatf("t4b_c%0d_count", c), count[0 +: W], 32'((c <= 4) ? c : 0));
      check_output($sformatf("t4b_c%0d_to", c), time_out[0], 0);
      check_output($sformatf("t4b_c%0d_expired", c), expired[0], 0);
      check_output($sformatf("t4b_c%0d_running", c), running[0], c < 5);
    end
    stop[0] = 1'b0;

    // all channels: thr=2,7,0(periodic),15
    stop = '1; expired_clr = '1;
    tick();
    stop = '0; expired_clr = '0;
    check_output("t5_idle_running", running, 0);
    check_output("t5_idle_expired", expired, 0);
    check_output("t5_idle_any", any_expired, 0);
    threshold = {32'd15, 32'd0, 32'd7, 32'd2};
    periodic = 4'b0100; start = 4'hF;
    tick();
    start = '0;
    check_output("t5_c0_count", count, 0);
    check_output("t5_c0_running", running, 4'hF);
    for (int c = 1; c <= 17; c++) begin
      expired_clr = {1'b0, c == 10, c == 8, c == 5};
      tick();
      exp_to  = {c == 16, 1'b1, c == 8, c == 3};
      exp_ex  = {c >= 16, 1'b1, c >= 8, (c >= 3) && (c < 5)};
      exp_run = {c < 16, 1'b1, c < 8, c < 3};
      exp_cnt = {32'((c < 16) ? c : 0), 32'd0, 32'((c < 8) ? c : 0), 32'((c < 3) ? c : 0)};
      check_output($sformatf("t5_c%0d_to", c), time_out, exp_to);
      check_output($sformatf("t5_c%0d_expired", c), expired, exp_ex);
      check_output($sformatf("t5_c%0d_running", c), running, exp_run);
      check_output($sformatf("t5_c%0d_count", c), count, exp_cnt);
      check_output($sformatf("t5_c%0d_any", c), any_expired, 1);
    end
    expired_clr = '0;

    // asynchronous reset mid-count, then idle until started again
    threshold[0 +: W] = 100; periodic[0] = 1'b0; start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    tick();
    tick();
    check_output("t6_pre_count", count[0 +: W], 2);
    #2 reset_n = 1'b0;
    #1;
    check_output("t6_rst_running", running, 0);
    check_output("t6_rst_to", time_out, 0);
    check_output("t6_rst_expired", expired, 0);
    check_output("t6_rst_count", count, 0);
    check_output("t6_rst_any", any_expired, 0);
    #3 reset_n = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      check_output($sformatf("t6_post%0d_running", c), running, 0);
      check_output($sformatf("t6_post%0d_count", c), count, 0);
    end
    threshold[0 +: W] = 2; start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    check_output("t6_go_running", running, 4'b0001);
    tick();
    tick();
    check_output("t6_go_c2_count", count[0 +: W], 2);
    tick();
    check_output("t6_go_c3_to", time_out, 4'b0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
